// File: rtl/btn_led_ctrl_if.sv
// Button/LED channel bundle between the board I/O layer and the front end.
interface btn_led_ctrl_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] i_btn;
    logic [N_CH-1:0] i_mode;
    logic [N_CH-1:0] o_led;
    logic [N_CH-1:0] o_press;
    logic [N_CH-1:0] o_release;
    logic [N_CH-1:0] o_state;

    modport master (
        output i_btn,
        output i_mode,
        input  o_led,
        input  o_press,
        input  o_release,
        input  o_state
    );

    modport slave (
        input  i_btn,
        input  i_mode,
        output o_led,
        output o_press,
        output o_release,
        output o_state
    );
endinterface

// File: rtl/btn_led_ctrl.sv
// Multi-channel push-button front end: synchronise, debounce, edge pulses and
// LED drive in toggle or momentary mode. Channels share no state.
module btn_led_ctrl #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    btn_led_ctrl_if.slave bus
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_CH-1:0] LED_POL  = LED_ACTIVE_LOW ? {N_CH{1'b1}} : {N_CH{1'b0}};

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] stable_q;
    logic [N_CH-1:0] led_on;
    logic [CW-1:0]   cnt      [N_CH];

    logic [N_CH-1:0] stable_next;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] led_next;
    logic [CW-1:0]   cnt_next [N_CH];

    // Debounce decision: any return of sync2 to the stable level restarts the count.
    always_comb begin
        stable_next = stable;
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Accepted edges and next LED state; the current mode applies to a press on this edge.
    always_comb begin
        rise     = stable & ~stable_q;
        fall     = ~stable & stable_q;
        led_next = (bus.i_mode & stable) | (~bus.i_mode & (led_on ^ rise));
    end

    // All per-channel state; o_led is registered directly from the next LED value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1         <= '0;
            sync2         <= '0;
            stable        <= '0;
            stable_q      <= '0;
            led_on        <= '0;
            bus.o_led     <= LED_POL;
            bus.o_press   <= '0;
            bus.o_release <= '0;
            bus.o_state   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1         <= bus.i_btn;
            sync2         <= sync1;
            stable        <= stable_next;
            stable_q      <= stable;
            led_on        <= led_next;
            bus.o_led     <= led_next ^ LED_POL;
            bus.o_press   <= rise;
            bus.o_release <= fall;
            bus.o_state   <= stable_next;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end
endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with N_CH=4, DEBOUNCE_CYCLES=4, active-low LEDs.
module tb_btn_led_ctrl;
    logic i_clk;
    logic i_rst_n;
    int   n_cmp;
    int   n_err;

    btn_led_ctrl_if #(.N_CH(4)) bus ();

    btn_led_ctrl #(
        .N_CH(4),
        .DEBOUNCE_CYCLES(4),
        .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    initial begin
        int glitch [9];
        glitch = '{1, 0, 1, 1, 0, 1, 1, 1, 0};
        n_cmp = 0;
        n_err = 0;

        // reset held with all buttons pressed
        i_rst_n    = 1'b0;
        bus.i_btn  = 4'b1111;
        bus.i_mode = 4'b0000;
        cyc(2);
        chk("rst_led", bus.o_led, 4'b1111);
        chk("rst_press", bus.o_press, 4'b0000);
        chk("rst_release", bus.o_release, 4'b0000);
        chk("rst_state", bus.o_state, 4'b0000);

        // held through reset release -> press after 7 edges
        i_rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            chk($sformatf("rstrel_press_k%0d", k), bus.o_press, (k == 7) ? 4'b1111 : 4'b0000);
            if (k == 6) chk("rstrel_state", bus.o_state, 4'b1111);
            if (k == 7) chk("rstrel_led", bus.o_led, 4'b0000);
        end
        bus.i_btn = 4'b0000;
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            chk($sformatf("rstrel_release_k%0d", k), bus.o_release, (k == 7) ? 4'b1111 : 4'b0000);
        end
        chk("rstrel_led_hold", bus.o_led, 4'b0000);

        // fresh reset
        i_rst_n = 1'b0;
        cyc(1);
        chk("rst2_led", bus.o_led, 4'b1111);
        i_rst_n = 1'b1;
        cyc(1);

        // clean press on ch0, toggle mode
        bus.i_btn = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("ch0_press_k%0d", k), bus.o_press, (k == 7) ? 4'b0001 : 4'b0000);
            chk($sformatf("ch0_led_k%0d", k), bus.o_led, (k >= 7) ? 4'b1110 : 4'b1111);
        end
        cyc(12);
        bus.i_btn = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("ch0_release_k%0d", k), bus.o_release, (k == 7) ? 4'b0001 : 4'b0000);
            chk($sformatf("ch0_relled_k%0d", k), bus.o_led, 4'b1110);
        end
        bus.i_btn = 4'b0001;
        cyc(7);
        chk("ch0_press2", bus.o_press, 4'b0001);
        chk("ch0_led2", bus.o_led, 4'b1111);
        bus.i_btn = 4'b0000;
        cyc(9);

        // bounce on ch1
        for (int k = 0; k < 9; k++) begin
            bus.i_btn = {2'b00, glitch[k][0], 1'b0};
            cyc(1);
            chk($sformatf("bounce_press_%0d", k), bus.o_press, 4'b0000);
            chk($sformatf("bounce_state_%0d", k), bus.o_state, 4'b0000);
        end
        bus.i_btn = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk($sformatf("bounce_final_k%0d", k), bus.o_press, (k == 7) ? 4'b0010 : 4'b0000);
        end
        chk("bounce_led", bus.o_led, 4'b1101);
        bus.i_btn = 4'b0000;
        cyc(9);

        // momentary mode on ch2
        bus.i_mode = 4'b0100;
        cyc(1);
        chk("mom_led_idle", bus.o_led, 4'b1101);
        bus.i_btn = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk($sformatf("mom_press_k%0d", k), bus.o_press, (k == 7) ? 4'b0100 : 4'b0000);
            chk($sformatf("mom_release_k%0d", k), bus.o_release, (k == 17) ? 4'b0100 : 4'b0000);
            chk($sformatf("mom_led_k%0d", k), bus.o_led, (k >= 7 && k < 17) ? 4'b1001 : 4'b1101);
            if (k == 10) bus.i_btn = 4'b0000;
        end
        bus.i_btn = 4'b0100;
        cyc(7);
        chk("mom2_press", bus.o_press, 4'b0100);
        chk("mom2_led", bus.o_led, 4'b1001);
        bus.i_mode = 4'b0000;
        cyc(3);
        chk("sw_led_hold", bus.o_led, 4'b1001);
        bus.i_btn = 4'b0000;
        cyc(9);
        chk("sw_led_after_rel", bus.o_led, 4'b1001);
        bus.i_btn = 4'b0100;
        cyc(7);
        chk("sw_press", bus.o_press, 4'b0100);
        chk("sw_led_toggle", bus.o_led, 4'b1101);
        bus.i_btn = 4'b0000;
        cyc(9);

        // all channels pressed together
        bus.i_btn = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            cyc(1);
            chk($sformatf("all_press_k%0d", k), bus.o_press, (k == 7) ? 4'b1111 : 4'b0000);
        end
        chk("all_led", bus.o_led, 4'b0010);
        bus.i_btn = 4'b0000;
        cyc(9);

        // reset mid-debounce on ch3
        bus.i_btn = 4'b1000;
        cyc(4);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_led", bus.o_led, 4'b1111);
        chk("midrst_press", bus.o_press, 4'b0000);
        chk("midrst_release", bus.o_release, 4'b0000);
        chk("midrst_state", bus.o_state, 4'b0000);
        cyc(2);
        bus.i_btn = 4'b0000;
        i_rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            chk($sformatf("midrst_nopress_k%0d", k), bus.o_press, 4'b0000);
            chk($sformatf("midrst_nostate_k%0d", k), bus.o_state, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
